// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8-bit UART transmitter, start/8N/parity/stop framing
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   tx_start  send request, level-sampled, accepted only while idle
//   tx_data   byte to send, captured on the accept cycle
//   tx_busy   high while a frame is accepted or in progress (combinational)
//   tx_done   one-cycle pulse during the last cycle of the final stop bit
//   txd       serial line, idle high, registered
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       txd
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] baud_cnt, cnt_next;
   logic [2:0]       bit_idx, idx_next;
   logic [7:0]       shift, shift_next;
   logic             parity_bit, parity_next;
   logic             busy_reg, busy_next;
   logic             txd_next;
   logic             done_next;
   logic             bit_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         parity_bit <= 1'b0;
         busy_reg   <= 1'b0;
         txd        <= 1'b1;
         tx_done    <= 1'b0;
      end else begin
         state      <= state_next;
         baud_cnt   <= cnt_next;
         bit_idx    <= idx_next;
         shift      <= shift_next;
         parity_bit <= parity_next;
         busy_reg   <= busy_next;
         txd        <= txd_next;
         tx_done    <= done_next;
      end
   end

   always_comb begin
      state_next  = state;
      cnt_next    = baud_cnt;
      idx_next    = bit_idx;
      shift_next  = shift;
      parity_next = parity_bit;
      busy_next   = busy_reg;
      bit_end     = (baud_cnt == CNT_LAST);

      // One counter paces every bit; it only runs outside IDLE.
      if (state != S_IDLE) begin
         cnt_next = bit_end ? '0 : baud_cnt + CNT_W'(1);
      end

      case (state)
         S_IDLE: begin
            cnt_next = '0;
            idx_next = '0;
            if (tx_start) begin
               shift_next  = tx_data;
               parity_next = (PARITY == 2) ? ~(^tx_data) : ^tx_data;
               busy_next   = 1'b1;
               state_next  = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               idx_next   = '0;
               state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_next = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  idx_next   = '0;
                  state_next = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  idx_next = bit_idx + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               idx_next   = '0;
               state_next = S_STOP;
            end
         end
         S_STOP: begin
            // bit_idx is reused here to count stop bits.
            if (bit_end) begin
               if (bit_idx == STOP_LAST) begin
                  idx_next   = '0;
                  busy_next  = 1'b0;
                  state_next = S_IDLE;
               end else begin
                  idx_next = bit_idx + 3'd1;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
         end
      endcase

      // txd is registered, so it is derived from where the FSM is going.
      case (state_next)
         S_START:  txd_next = 1'b0;
         S_DATA:   txd_next = shift_next[0];
         S_PARITY: txd_next = parity_next;
         default:  txd_next = 1'b1;
      endcase

      // Registered pulse lands on the last cycle of the final stop bit,
      // so the line goes idle on the cycle right after tx_done.
      done_next = (state_next == S_STOP) && (idx_next == STOP_LAST) &&
                  (cnt_next == CNT_LAST);
   end

   // Combinational accept term lets the upstream FSM see busy immediately.
   assign tx_busy = busy_reg | (tx_start & (state == S_IDLE) & ~rst);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - bench for uart_tx_serializer, four parameter sets in parallel
module tb_uart_tx_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [3:0] busy_v, done_v, txd_v;
   logic       chk_en = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // 0: no parity, 1 stop; 1: even; 2: odd; 3: no parity, 2 stop. All at 4 clk/bit.
   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(busy_v[0]), .tx_done(done_v[0]), .txd(txd_v[0]));
   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(busy_v[1]), .tx_done(done_v[1]), .txd(txd_v[1]));
   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dut2 (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(busy_v[2]), .tx_done(done_v[2]), .txd(txd_v[2]));
   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) dut3 (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(busy_v[3]), .tx_done(done_v[3]), .txd(txd_v[3]));

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   function automatic int par_of(input int k);
      case (k)
         1: return 1;
         2: return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int stop_of(input int k);
      return (k == 3) ? 2 : 1;
   endfunction

   function automatic int len_of(input int k);
      return 4 * (10 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k) - 1);
   endfunction

   // Frame as a bit list, bit 0 first on the wire; trailing ones are stop bits.
   function automatic logic [11:0] frame_of(input int k, input logic [7:0] d);
      logic [11:0] f;
      f = '1;
      f[0] = 1'b0;
      f[8:1] = d;
      if (par_of(k) == 1) f[9] = ^d;
      else if (par_of(k) == 2) f[9] = ~(^d);
      return f;
   endfunction

   // Model: position within the current frame in clk cycles, -1 when idle.
   int          m_pos [4] = '{-1, -1, -1, -1};
   logic [11:0] m_frame [4];

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (rst) begin
            m_pos[k] <= -1;
         end else if (m_pos[k] < 0) begin
            if (tx_start) begin
               m_pos[k]   <= 0;
               m_frame[k] <= frame_of(k, tx_data);
            end
         end else if (m_pos[k] == len_of(k) - 1) begin
            m_pos[k] <= -1;
         end else begin
            m_pos[k] <= m_pos[k] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 4; k++) begin
            chk("model_txd", k, 32'(txd_v[k]),
                32'((m_pos[k] < 0) ? 1'b1 : m_frame[k][m_pos[k] / 4]));
            chk("model_done", k, 32'(done_v[k]), 32'(m_pos[k] == len_of(k) - 1));
            chk("model_busy", k, 32'(busy_v[k]),
                32'((m_pos[k] >= 0) || (tx_start && !rst)));
         end
      end
   end

   // Per-cycle capture, index 1 = first START cycle of the frame under test.
   logic [3:0] r_txd [0:127];
   logic [3:0] r_done [0:127];
   logic [3:0] r_busy [0:127];

   task automatic step(input int c);
      @(negedge clk);
      r_txd[c]  = txd_v;
      r_done[c] = done_v;
      r_busy[c] = busy_v;
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [7:0] d, input logic hold);
      @(posedge clk);
      #1;
      tx_start = 1'b1;
      tx_data  = d;
      @(negedge clk);
      chk("busy_same_cycle", 0, 32'(busy_v[0]), 32'd1);
      @(posedge clk);
      #1;
      if (!hold) tx_start = 1'b0;
   endtask

   function automatic int done_at(input int k, input int n);
      for (int c = 1; c <= n; c++) if (r_done[c][k]) return c;
      return 0;
   endfunction

   function automatic int done_cnt(input int k, input int n);
      int s = 0;
      for (int c = 1; c <= n; c++) if (r_done[c][k]) s++;
      return s;
   endfunction

   function automatic int low_cnt(input int k, input int a, input int b);
      int s = 0;
      for (int c = a; c <= b; c++) if (!r_txd[c][k]) s++;
      return s;
   endfunction

   function automatic logic [9:0] bits10(input int k);
      logic [9:0] v;
      for (int b = 0; b < 10; b++) v[b] = r_txd[4 * b + 2][k];
      return v;
   endfunction

   initial begin
      // Reset with tx_start high: busy must stay low.
      rst = 1'b1;
      tx_start = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_txd", 0, 32'(txd_v), 32'hF);
      chk("rst_done", 0, 32'(done_v), 32'h0);
      chk("rst_busy", 0, 32'(busy_v), 32'h0);
      @(posedge clk);
      #1;
      tx_start = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Single 0x41 frame on all four configurations.
      start_frame(8'h41, 1'b0);
      for (int c = 1; c <= 50; c++) step(c);
      chk("t1_bits", 0, 32'(bits10(0)), 32'h282);
      chk("t1_done_at", 0, done_at(0, 50), 40);
      chk("t1_done_at", 1, done_at(1, 50), 44);
      chk("t1_done_at", 2, done_at(2, 50), 44);
      chk("t1_done_at", 3, done_at(3, 50), 44);
      chk("t1_busy_after", 0, 32'(r_busy[41][0]), 32'd0);
      chk("t1_even_par", 1, 32'(r_txd[38][1]), 32'd0);
      chk("t1_odd_par", 2, 32'(r_txd[38][2]), 32'd1);

      // 0x07: three ones.
      start_frame(8'h07, 1'b0);
      for (int c = 1; c <= 50; c++) step(c);
      chk("t2_even_par", 1, 32'(r_txd[38][1]), 32'd1);
      chk("t2_odd_par", 2, 32'(r_txd[38][2]), 32'd0);

      // 0xFF with two stop bits.
      start_frame(8'hFF, 1'b0);
      for (int c = 1; c <= 50; c++) step(c);
      chk("t3_low", 3, low_cnt(3, 1, 50), 4);
      chk("t3_high", 3, low_cnt(3, 5, 44), 0);
      chk("t3_done_at", 3, done_at(3, 50), 44);

      // tx_start held: back-to-back frames, data changes mid-frame.
      start_frame(8'h41, 1'b1);
      for (int c = 1; c <= 100; c++) begin
         if (c == 2) tx_data = 8'h00;
         if (c == 20) tx_data = 8'h42;
         if (c == 47) tx_start = 1'b0;
         step(c);
      end
      chk("t4_first_bits", 0, 32'(bits10(0)), 32'h282);
      chk("t4_idle_gap", 0, 32'(r_txd[41][0]), 32'd1);
      chk("t4_second_start", 0, low_cnt(0, 42, 45), 4);
      chk("t4_second_b0", 0, 32'(r_txd[47][0]), 32'd0);
      chk("t4_second_b1", 0, 32'(r_txd[51][0]), 32'd1);
      chk("t4_done_cnt", 0, done_cnt(0, 100), 2);
      chk("t4_done_cnt", 3, done_cnt(3, 100), 2);

      // Reset during data bit 3, then a clean 0x55 frame.
      start_frame(8'h41, 1'b0);
      for (int c = 1; c <= 60; c++) begin
         if (c == 18) rst = 1'b1;
         if (c == 19) rst = 1'b0;
         step(c);
      end
      chk("t5_txd", 0, 32'(r_txd[19]), 32'hF);
      chk("t5_busy", 0, 32'(r_busy[19]), 32'h0);
      chk("t5_no_done", 0, done_cnt(0, 60), 0);
      start_frame(8'h55, 1'b0);
      for (int c = 1; c <= 50; c++) step(c);
      chk("t5_bits", 0, 32'(bits10(0)), 32'h2AA);
      chk("t5_done_at", 0, done_at(0, 50), 40);

      // Start pulse while busy must be ignored.
      start_frame(8'h41, 1'b0);
      for (int c = 1; c <= 90; c++) begin
         if (c == 15) begin
            tx_start = 1'b1;
            tx_data  = 8'h00;
         end
         if (c == 16) tx_start = 1'b0;
         step(c);
      end
      chk("t6_busy_mid", 0, 32'(r_busy[15][0]), 32'd1);
      chk("t6_bits", 0, 32'(bits10(0)), 32'h282);
      chk("t6_done_cnt", 0, done_cnt(0, 90), 1);
      chk("t6_done_at", 0, done_at(0, 90), 40);
      chk("t6_done_cnt", 3, done_cnt(3, 90), 1);

      repeat (4) @(posedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
